// File: rtl/hbridge_seq_if.sv
// rtl/hbridge_seq_if.sv - handshake and bridge-control bundle for hbridge_seq
//
// Purpose: groups the configuration, start/abort handshake and bridge outputs
// of the H-bridge sequencer so the pulse-program controller and the
// sequencer connect through one port.
//
// Signals:
//   load                         shadow-register write strobe
//   cfg_half/cfg_dead/cfg_dump   half-period H, dead time D, dump interval P (CNT_W)
//   cfg_cycles                   cycle count N (NUM_W)
//   start, abort                 burst request / stop request
//   forward, back, dumpoff_ctrl  bridge controls
//   busy, done, cfg_err          status
//
// Modports: master = pulse-program controller, slave = sequencer.
interface hbridge_seq_if #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 10
);
  logic             load;
  logic [CNT_W-1:0] cfg_half;
  logic [CNT_W-1:0] cfg_dead;
  logic [NUM_W-1:0] cfg_cycles;
  logic [CNT_W-1:0] cfg_dump;
  logic             start;
  logic             abort;
  logic             forward;
  logic             back;
  logic             dumpoff_ctrl;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output load, cfg_half, cfg_dead, cfg_cycles, cfg_dump, start, abort,
    input  forward, back, dumpoff_ctrl, busy, done, cfg_err
  );

  modport slave (
    input  load, cfg_half, cfg_dead, cfg_cycles, cfg_dump, start, abort,
    output forward, back, dumpoff_ctrl, busy, done, cfg_err
  );
endinterface

// File: rtl/hbridge_seq.sv
// rtl/hbridge_seq.sv - H-bridge excitation sequencer with dead time and dump phase
//
// Purpose: drives forward/back bridge legs for N cycles of half-period H with
// D clocks of dead time at the end of each half, then holds dumpoff_ctrl for
// P clocks. Configuration is written to shadow registers with load and copied
// to active registers when a start is accepted in IDLE.
//
// Ports:
//   clkin   system clock
//   reset   asynchronous, active-high reset
//   bus     hbridge_seq_if.slave (config, start/abort, bridge controls, status)
//
// Optional build macro: HBRIDGE_CONT_EN - N=0 selects continuous cycling
// until abort; without it N=0 is rejected with cfg_err.
module hbridge_seq #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 10
) (
  input  logic         clkin,
  input  logic         reset,
  hbridge_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FWD   = 3'd1;
  localparam logic [2:0] S_DEAD1 = 3'd2;
  localparam logic [2:0] S_BACK  = 3'd3;
  localparam logic [2:0] S_DEAD2 = 3'd4;
  localparam logic [2:0] S_DUMP  = 3'd5;

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] phase_cnt, cnt_nx;
  logic [NUM_W-1:0] cyc_cnt, cyc_nx, cyc_inc;
  logic [CNT_W-1:0] sh_half, sh_dead, sh_dump;
  logic [NUM_W-1:0] sh_cycles;
  logic [CNT_W-1:0] act_half, act_dead, act_dump;
  logic [NUM_W-1:0] act_cycles;
  logic             start_q, start_nx;
  logic             done_q, done_nx;
  logic             err_q, err_nx;
  logic             cfg_ok, more_cycles, cycle_end;
  logic [CNT_W-1:0] on_len_m1;

  // Drive length minus one; D<H is guaranteed once a start is accepted.
  assign on_len_m1 = act_half - act_dead - CNT_W'(1);
  // Saturating increment so a long continuous run never wraps.
  assign cyc_inc   = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + NUM_W'(1);

`ifdef HBRIDGE_CONT_EN
  assign cfg_ok      = (act_half != '0) && (act_dead < act_half);
  assign more_cycles = (act_cycles == '0) || (cyc_inc < act_cycles);
`else
  assign cfg_ok      = (act_half != '0) && (act_dead < act_half) && (act_cycles != '0);
  assign more_cycles = (cyc_inc < act_cycles);
`endif

  // A start is captured (and the shadow copied) at one edge and validated at
  // the next, which is why forward/busy/cfg_err appear one clock after start.
  always_comb begin
    state_nx  = state;
    cnt_nx    = phase_cnt;
    cyc_nx    = cyc_cnt;
    start_nx  = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    cycle_end = 1'b0;
    if (state == S_IDLE) begin
      if (start_q) begin
        if (cfg_ok) begin
          state_nx = S_FWD;
          cnt_nx   = on_len_m1;
          cyc_nx   = '0;
        end else begin
          err_nx = 1'b1;
        end
      end else begin
        start_nx = bus.start & ~bus.abort;
      end
    end else if (bus.abort && (state != S_DUMP)) begin
      if (act_dump == '0) begin
        state_nx = S_IDLE;
        done_nx  = 1'b1;
      end else begin
        state_nx = S_DUMP;
        cnt_nx   = act_dump - CNT_W'(1);
      end
    end else if (phase_cnt != '0) begin
      cnt_nx = phase_cnt - CNT_W'(1);
    end else begin
      case (state)
        S_FWD: begin
          if (act_dead == '0) begin
            state_nx = S_BACK;
            cnt_nx   = on_len_m1;
          end else begin
            state_nx = S_DEAD1;
            cnt_nx   = act_dead - CNT_W'(1);
          end
        end
        S_DEAD1: begin
          state_nx = S_BACK;
          cnt_nx   = on_len_m1;
        end
        S_BACK: begin
          if (act_dead == '0) begin
            cycle_end = 1'b1;
          end else begin
            state_nx = S_DEAD2;
            cnt_nx   = act_dead - CNT_W'(1);
          end
        end
        S_DEAD2: cycle_end = 1'b1;
        S_DUMP: begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
        default: state_nx = S_IDLE;
      endcase
      if (cycle_end) begin
        cyc_nx = cyc_inc;
        if (more_cycles) begin
          state_nx = S_FWD;
          cnt_nx   = on_len_m1;
        end else if (act_dump == '0) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = S_DUMP;
          cnt_nx   = act_dump - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      cyc_cnt    <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sh_half    <= '0;
      sh_dead    <= '0;
      sh_cycles  <= '0;
      sh_dump    <= '0;
      act_half   <= '0;
      act_dead   <= '0;
      act_cycles <= '0;
      act_dump   <= '0;
    end else begin
      state     <= state_nx;
      phase_cnt <= cnt_nx;
      cyc_cnt   <= cyc_nx;
      start_q   <= start_nx;
      done_q    <= done_nx;
      err_q     <= err_nx;
      if (bus.load) begin
        sh_half   <= bus.cfg_half;
        sh_dead   <= bus.cfg_dead;
        sh_cycles <= bus.cfg_cycles;
        sh_dump   <= bus.cfg_dump;
      end
      // Copies the pre-load shadow when load and start share an edge.
      if (start_nx) begin
        act_half   <= sh_half;
        act_dead   <= sh_dead;
        act_cycles <= sh_cycles;
        act_dump   <= sh_dump;
      end
    end
  end

  // Both legs decode from the one state register, so they can never overlap.
  assign bus.forward      = (state == S_FWD);
  assign bus.back         = (state == S_BACK);
  assign bus.dumpoff_ctrl = (state == S_DUMP);
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = done_q;
  assign bus.cfg_err      = err_q;

endmodule

// File: tb/tb_hbridge_seq.sv
// tb/tb_hbridge_seq.sv - self-checking bench for hbridge_seq
module tb_hbridge_seq;

  logic clkin = 1'b0;
  logic reset;

  hbridge_seq_if #(.CNT_W(16), .NUM_W(10)) bus ();

  hbridge_seq #(.CNT_W(16), .NUM_W(10)) dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] obs [0:255];
  int ld_h, ld_d, ld_n, ld_p;

  // {forward, back, dumpoff_ctrl, busy, done, cfg_err}
  function automatic logic [5:0] sample();
    return {bus.forward, bus.back, bus.dumpoff_ctrl, bus.busy, bus.done, bus.cfg_err};
  endfunction

  // Expected outputs after edge t for an accepted start sampled at edge 0.
  // Drive phase occupies edges 1..2HN (or up to the abort edge), the dump
  // window follows for P edges, then a single done edge.
  function automatic logic [5:0] model(int t, int h, int d, int n, int p, int ab);
    int burst, stop, pos;
    logic [5:0] v;
    v = '0;
    burst = 2 * h * n;
    stop = (ab >= 2 && ab <= burst) ? ab : burst + 1;
    if (t >= 1 && t < stop) begin
      pos  = (t - 1) % (2 * h);
      v[5] = (pos < h - d);
      v[4] = (pos >= h) && (pos < 2 * h - d);
      v[2] = 1'b1;
    end else if (t >= stop && t < stop + p) begin
      v[3] = 1'b1;
      v[2] = 1'b1;
    end else if (t == stop + p) begin
      v[1] = 1'b1;
    end
    return v;
  endfunction

  function automatic int end_edge(int h, int n, int p, int ab);
    int burst;
    burst = 2 * h * n;
    return ((ab >= 2 && ab <= burst) ? ab : burst + 1) + p;
  endfunction

  task automatic do_load(input int h, input int d, input int n, input int p);
    @(negedge clkin);
    bus.cfg_half   = 16'(h);
    bus.cfg_dead   = 16'(d);
    bus.cfg_cycles = 10'(n);
    bus.cfg_dump   = 16'(p);
    bus.load       = 1'b1;
    @(negedge clkin);
    bus.load = 1'b0;
  endtask

  // Called at a negedge: raises start for edge 0 and records outputs after
  // edges 0..len. ab/st_at/ld_at name the edge at which abort, an extra
  // start, or a shadow load (ld_*) is sampled; -1 means never.
  task automatic capture(input int len, input int ab, input int st_at, input int ld_at);
    bus.start = 1'b1;
    bus.abort = (ab == 0);
    for (int t = 0; t <= len; t++) begin
      @(negedge clkin);
      obs[t]    = sample();
      bus.start = (t + 1 == st_at);
      bus.abort = (t + 1 == ab);
      bus.load  = (t + 1 == ld_at);
      if (t + 1 == ld_at) begin
        bus.cfg_half   = 16'(ld_h);
        bus.cfg_dead   = 16'(ld_d);
        bus.cfg_cycles = 10'(ld_n);
        bus.cfg_dump   = 16'(ld_p);
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.load  = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    got = sample();
    n_checks++;
    if (got !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_state got=%b exp=%b", got, 6'b0);
    end
    @(negedge clkin);
    reset = 1'b0;
    @(negedge clkin);
    got = sample();
    n_checks++;
    if (got !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_release got=%b exp=%b", got, 6'b0);
    end
  endtask

  task automatic test_basic();
    logic [5:0] e;
    int len;
    do_load(8, 2, 3, 5);
    len = end_edge(8, 3, 5, -1) + 2;
    capture(len, -1, -1, -1);
    for (int t = 0; t <= len; t++) begin
      e = model(t, 8, 2, 3, 5, -1);
      n_checks++;
      if (obs[t] !== e) begin
        n_errors++;
        $display("FAIL basic edge=%0d got=%b exp=%b", t, obs[t], e);
      end
    end
  endtask

  task automatic test_reject();
    logic [5:0] e;
    int cfgs [3][4];
    cfgs[0] = '{4, 4, 3, 5};
    cfgs[1] = '{0, 0, 3, 5};
    cfgs[2] = '{5, 7, 2, 1};
    for (int c = 0; c < 3; c++) begin
      do_load(cfgs[c][0], cfgs[c][1], cfgs[c][2], cfgs[c][3]);
      capture(4, -1, -1, -1);
      for (int t = 0; t <= 4; t++) begin
        e = (t == 1) ? 6'b000001 : 6'b000000;
        n_checks++;
        if (obs[t] !== e) begin
          n_errors++;
          $display("FAIL reject cfg=%0d edge=%0d got=%b exp=%b", c, t, obs[t], e);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [5:0] e;
    int ab, len;
    do_load(8, 2, 3, 5);
    ab  = 27;   // second BACK spans edges 25..30
    len = end_edge(8, 3, 5, ab) + 3;
    capture(len, ab, -1, -1);
    for (int t = 0; t <= len; t++) begin
      e = model(t, 8, 2, 3, 5, ab);
      n_checks++;
      if (obs[t] !== e) begin
        n_errors++;
        $display("FAIL abort edge=%0d got=%b exp=%b", t, obs[t], e);
      end
    end
    // abort with P=0 finishes immediately with done
    do_load(4, 1, 2, 0);
    ab  = 6;
    len = end_edge(4, 2, 0, ab) + 2;
    capture(len, ab, -1, -1);
    for (int t = 0; t <= len; t++) begin
      e = model(t, 4, 1, 2, 0, ab);
      n_checks++;
      if (obs[t] !== e) begin
        n_errors++;
        $display("FAIL abort_nodump edge=%0d got=%b exp=%b", t, obs[t], e);
      end
    end
  endtask

  task automatic test_start_abort_same();
    logic [5:0] e;
    do_load(8, 2, 3, 5);
    capture(5, 0, -1, -1);
    e = 6'b0;
    for (int t = 0; t <= 5; t++) begin
      n_checks++;
      if (obs[t] !== e) begin
        n_errors++;
        $display("FAIL start_abort edge=%0d got=%b exp=%b", t, obs[t], e);
      end
    end
  endtask

  task automatic test_load_midburst();
    logic [5:0] e;
    int len;
    do_load(8, 2, 3, 5);
    ld_h = 16; ld_d = 2; ld_n = 3; ld_p = 5;
    len = end_edge(8, 3, 5, -1);
    capture(len, -1, 12, 10);   // also a start while busy, to be ignored
    for (int t = 0; t <= len; t++) begin
      e = model(t, 8, 2, 3, 5, -1);
      n_checks++;
      if (obs[t] !== e) begin
        n_errors++;
        $display("FAIL load_mid_old edge=%0d got=%b exp=%b", t, obs[t], e);
      end
    end
    // back-to-back: start sampled on the edge right after done
    len = end_edge(16, 3, 5, -1);
    capture(len, -1, -1, -1);
    for (int t = 0; t <= len; t++) begin
      e = model(t, 16, 2, 3, 5, -1);
      n_checks++;
      if (obs[t] !== e) begin
        n_errors++;
        $display("FAIL load_mid_new edge=%0d got=%b exp=%b", t, obs[t], e);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] e;
    int h, d, n, p, ab, st, len, burst;
    for (int i = 0; i < 12; i++) begin
      h = $urandom_range(1, 6);
      d = $urandom_range(0, h - 1);
      n = $urandom_range(1, 3);
      p = $urandom_range(0, 4);
      burst = 2 * h * n;
      ab = ($urandom_range(0, 1) == 1 && burst >= 2) ? $urandom_range(2, burst) : -1;
      st = $urandom_range(2, (ab > 0) ? ab : burst + 1);
      do_load(h, d, n, p);
      len = end_edge(h, n, p, ab);
      capture(len, ab, st, -1);
      for (int t = 0; t <= len; t++) begin
        e = model(t, h, d, n, p, ab);
        n_checks++;
        if (obs[t] !== e) begin
          n_errors++;
          $display("FAIL random it=%0d H=%0d D=%0d N=%0d P=%0d ab=%0d edge=%0d got=%b exp=%b",
                   i, h, d, n, p, ab, t, obs[t], e);
        end
      end
    end
  endtask

  task automatic test_cont();
    logic [5:0] e;
`ifdef HBRIDGE_CONT_EN
    int ab, len;
    do_load(3, 1, 0, 2);
    ab  = 65;   // more than ten 6-clock cycles before abort
    len = ab + 2 + 2;
    capture(len, ab, -1, -1);
    for (int t = 0; t <= len; t++) begin
      e = model(t, 3, 1, 1000, 2, ab);
      n_checks++;
      if (obs[t] !== e) begin
        n_errors++;
        $display("FAIL cont edge=%0d got=%b exp=%b", t, obs[t], e);
      end
    end
`else
    do_load(8, 2, 0, 5);
    capture(4, -1, -1, -1);
    for (int t = 0; t <= 4; t++) begin
      e = (t == 1) ? 6'b000001 : 6'b000000;
      n_checks++;
      if (obs[t] !== e) begin
        n_errors++;
        $display("FAIL n_zero_reject edge=%0d got=%b exp=%b", t, obs[t], e);
      end
    end
`endif
  endtask

  task automatic test_reset_midburst();
    logic [5:0] got, e;
    do_load(8, 2, 3, 5);
    bus.start = 1'b1;
    @(negedge clkin);
    bus.start = 1'b0;
    repeat (2) @(negedge clkin);
    got = sample();
    n_checks++;
    if (got !== 6'b100100) begin
      n_errors++;
      $display("FAIL pre_reset_fwd got=%b exp=%b", got, 6'b100100);
    end
    #2 reset = 1'b1;
    #1 got = sample();
    n_checks++;
    if (got !== 6'b0) begin
      n_errors++;
      $display("FAIL async_reset got=%b exp=%b", got, 6'b0);
    end
    @(negedge clkin);
    reset = 1'b0;
    capture(4, -1, -1, -1);
    for (int t = 0; t <= 4; t++) begin
      e = (t == 1) ? 6'b000001 : 6'b000000;
      n_checks++;
      if (obs[t] !== e) begin
        n_errors++;
        $display("FAIL post_reset_reject edge=%0d got=%b exp=%b", t, obs[t], e);
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.load       = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.cfg_half   = '0;
    bus.cfg_dead   = '0;
    bus.cfg_cycles = '0;
    bus.cfg_dump   = '0;
    ld_h = 0; ld_d = 0; ld_n = 0; ld_p = 0;
    repeat (2) @(negedge clkin);
    test_reset();
    test_basic();
    test_reject();
    test_abort();
    test_start_abort_same();
    test_load_midburst();
    test_random();
    test_cont();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
